// File: rtl/ospi_host_ctrl.sv
// x8 SDR OSPI host: serialises read/program/erase requests into
// command/address/dummy/data beats of two clk cycles each.
module ospi_host_ctrl #(
  parameter int WIDTH        = 8,
  parameter int ADDR_BYTES   = 1,
  parameter int DUMMY_CYCLES = 4,
  parameter int CS_HIGH_MIN  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_op,
  input  logic [8*ADDR_BYTES-1:0] req_addr,
  input  logic [WIDTH-1:0]        req_data,
  output logic                    rsp_valid,
  output logic [WIDTH-1:0]        rsp_data,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    OSPI_CLK,
  output logic                    OSPI_CS,
  output logic [WIDTH-1:0]        io_out,
  output logic                    io_oe,
  input  logic [WIDTH-1:0]        io_in
);

  localparam int AW = 8*ADDR_BYTES;
  localparam logic [7:0] GAP_LAST = 8'(CS_HIGH_MIN-1);
  localparam logic [7:0] ADR_LAST = 8'(ADDR_BYTES-1);
  localparam logic [7:0] DUM_LAST = 8'(DUMMY_CYCLES-1);
  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_PG = 2'b01;

  typedef enum logic [2:0] {
    IDLE, WREN, WREN_GAP, CMD, ADDR, DUMMY, DATA, GAP
  } state_e;

  state_e           state_q, state_d;
  logic             phase_q, phase_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      cnt_q       <= '0;
      op_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = 1'b0;
    cnt_d       = cnt_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    unique case (state_q)
      IDLE: if (req_valid) begin
        op_d   = req_op;
        addr_d = req_addr;
        data_d = req_data;
        cnt_d  = '0;
        case (req_op)
          2'b00:        state_d = CMD;
          2'b01, 2'b10: state_d = WREN;
          default: begin
            // illegal op: single response cycle, no pin activity
            state_d     = GAP;
            cnt_d       = GAP_LAST;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        endcase
      end
      WREN: begin
        phase_d = !phase_q;
        if (phase_q) begin
          state_d = WREN_GAP;
          cnt_d   = '0;
        end
      end
      WREN_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = CMD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      CMD: begin
        phase_d = !phase_q;
        if (phase_q) begin
          state_d = ADDR;
          cnt_d   = '0;
        end
      end
      ADDR: begin
        phase_d = !phase_q;
        if (phase_q) begin
          addr_d = addr_q << 8;
          if (cnt_q == ADR_LAST) begin
            cnt_d = '0;
            case (op_q)
              OP_RD:   state_d = (DUMMY_CYCLES > 0) ? DUMMY : DATA;
              OP_PG:   state_d = DATA;
              default: begin
                state_d     = GAP;
                rsp_valid_d = 1'b1;
              end
            endcase
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      DUMMY: begin
        phase_d = !phase_q;
        if (phase_q) begin
          if (cnt_q == DUM_LAST) begin
            state_d = DATA;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      DATA: begin
        phase_d = !phase_q;
        if (phase_q) begin
          if (op_q == OP_RD) rsp_data_d = io_in;
          state_d     = GAP;
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) state_d = IDLE;
        else cnt_d = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    OSPI_CS = 1'b1;
    io_oe   = 1'b0;
    io_out  = '0;
    unique case (state_q)
      WREN: begin
        OSPI_CS = 1'b0;
        io_oe   = 1'b1;
        io_out  = WIDTH'(8'h06);
      end
      CMD: begin
        OSPI_CS = 1'b0;
        io_oe   = 1'b1;
        case (op_q)
          OP_RD:   io_out = WIDTH'(8'h03);
          OP_PG:   io_out = WIDTH'(8'h02);
          default: io_out = WIDTH'(8'h20);
        endcase
      end
      ADDR: begin
        OSPI_CS = 1'b0;
        io_oe   = 1'b1;
        io_out  = WIDTH'(addr_q[AW-1 -: 8]);
      end
      DUMMY: OSPI_CS = 1'b0;
      DATA: begin
        OSPI_CS = 1'b0;
        if (op_q == OP_PG) begin
          io_oe  = 1'b1;
          io_out = data_q;
        end
      end
      default: ;
    endcase
    OSPI_CLK = !OSPI_CS && phase_q;
  end

  assign req_ready = (state_q == IDLE) && !reset;
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_ospi_host_ctrl.sv
// Directed bench for ospi_host_ctrl: per-cycle pin traces after
// acceptance are compared against hand-derived expectations.
module tb_ospi_host_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_op = 2'b00;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_data = 8'h00;
  logic [7:0] io_in = 8'h00;
  logic       req_ready, rsp_valid, rsp_err, busy;
  logic       OSPI_CLK, OSPI_CS, io_oe;
  logic [7:0] rsp_data, io_out;

  ospi_host_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .OSPI_CLK(OSPI_CLK), .OSPI_CS(OSPI_CS),
    .io_out(io_out), .io_oe(io_oe), .io_in(io_in)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  localparam logic [39:0] EVEN = 40'h55_5555_5555;

  logic [39:0] cl_v, ck_v, oe_v, rv_v, bz_v, ry_v;
  logic [7:0]  out_a [0:39];
  logic [7:0]  rd_a  [0:39];
  logic        er_a  [0:39];

  function automatic logic [39:0] rng(input int lo, input int hi);
    logic [39:0] r = '0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  task automatic clr();
    cl_v = '0; ck_v = '0; oe_v = '0;
    rv_v = '0; bz_v = '0; ry_v = '0;
  endtask

  task automatic sample(input int k);
    cl_v[k] = !OSPI_CS;
    ck_v[k] = OSPI_CLK;
    oe_v[k] = io_oe;
    rv_v[k] = rsp_valid;
    bz_v[k] = busy;
    ry_v[k] = req_ready;
    out_a[k] = io_out;
    rd_a[k]  = rsp_data;
    er_a[k]  = rsp_err;
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = a; req_data = d;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL issue_ready got=%b want=1", req_ready);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_addr = 8'hFF; req_data = 8'hFF;
  endtask

  task automatic capture(input int n);
    clr();
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      sample(k);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({OSPI_CS, OSPI_CLK, io_oe, rsp_valid, rsp_err, busy, req_ready}
        !== 7'b1000000) begin
      bad++;
      $display("FAIL reset_ctl got=%b want=1000000",
        {OSPI_CS, OSPI_CLK, io_oe, rsp_valid, rsp_err, busy, req_ready});
    end
    total++;
    if ({io_out, rsp_data} !== 16'h0000) begin
      bad++;
      $display("FAIL reset_data got=%h want=0000", {io_out, rsp_data});
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b want=1", req_ready);
    end
  endtask

  task automatic test_read();
    io_in = 8'hC3;
    issue(2'b00, 8'h5A, 8'h00);
    capture(18);
    total++;
    if (cl_v !== rng(1, 14)) begin
      bad++; $display("FAIL rd_cs got=%h want=%h", cl_v, rng(1, 14));
    end
    total++;
    if (ck_v !== (rng(1, 14) & EVEN)) begin
      bad++; $display("FAIL rd_clk got=%h want=%h", ck_v, rng(1, 14) & EVEN);
    end
    total++;
    if (oe_v !== rng(1, 4)) begin
      bad++; $display("FAIL rd_oe got=%h want=%h", oe_v, rng(1, 4));
    end
    total++;
    if ({out_a[1], out_a[3]} !== 16'h035A) begin
      bad++; $display("FAIL rd_io got=%h%h want=035a", out_a[1], out_a[3]);
    end
    total++;
    if (rv_v !== rng(15, 15)) begin
      bad++; $display("FAIL rd_rsp got=%h want=%h", rv_v, rng(15, 15));
    end
    total++;
    if ({rd_a[15], er_a[15]} !== {8'hC3, 1'b0}) begin
      bad++; $display("FAIL rd_data got=%h/%b want=c3/0", rd_a[15], er_a[15]);
    end
    total++;
    if (bz_v !== rng(1, 16)) begin
      bad++; $display("FAIL rd_busy got=%h want=%h", bz_v, rng(1, 16));
    end
    total++;
    if (ry_v !== rng(17, 18)) begin
      bad++; $display("FAIL rd_ready got=%h want=%h", ry_v, rng(17, 18));
    end
  endtask

  task automatic test_program();
    logic [39:0] lo;
    io_in = 8'h00;
    issue(2'b01, 8'h10, 8'hA5);
    capture(14);
    lo = rng(1, 2) | rng(5, 10);
    total++;
    if (cl_v !== lo) begin
      bad++; $display("FAIL pg_cs got=%h want=%h", cl_v, lo);
    end
    total++;
    if (ck_v !== (lo & EVEN)) begin
      bad++; $display("FAIL pg_clk got=%h want=%h", ck_v, lo & EVEN);
    end
    total++;
    if (oe_v !== lo) begin
      bad++; $display("FAIL pg_oe got=%h want=%h", oe_v, lo);
    end
    total++;
    if ({out_a[1], out_a[5], out_a[7], out_a[9]} !== 32'h060210A5) begin
      bad++;
      $display("FAIL pg_io got=%h %h %h %h want=06 02 10 a5",
        out_a[1], out_a[5], out_a[7], out_a[9]);
    end
    total++;
    if (rv_v !== rng(11, 11) || er_a[11] !== 1'b0) begin
      bad++; $display("FAIL pg_rsp got=%h want=%h", rv_v, rng(11, 11));
    end
    total++;
    if (rd_a[11] !== 8'hC3) begin
      bad++; $display("FAIL pg_hold got=%h want=c3", rd_a[11]);
    end
    total++;
    if (ry_v !== rng(13, 14)) begin
      bad++; $display("FAIL pg_ready got=%h want=%h", ry_v, rng(13, 14));
    end
  endtask

  task automatic test_erase();
    logic [39:0] lo;
    issue(2'b10, 8'h80, 8'h00);
    capture(12);
    lo = rng(1, 2) | rng(5, 8);
    total++;
    if (cl_v !== lo || oe_v !== lo) begin
      bad++; $display("FAIL er_cs got=%h/%h want=%h", cl_v, oe_v, lo);
    end
    total++;
    if (ck_v !== (lo & EVEN)) begin
      bad++; $display("FAIL er_clk got=%h want=%h", ck_v, lo & EVEN);
    end
    total++;
    if ({out_a[1], out_a[5], out_a[7]} !== 24'h062080) begin
      bad++;
      $display("FAIL er_io got=%h %h %h want=06 20 80",
        out_a[1], out_a[5], out_a[7]);
    end
    total++;
    if (rv_v !== rng(9, 9) || er_a[9] !== 1'b0) begin
      bad++; $display("FAIL er_rsp got=%h want=%h", rv_v, rng(9, 9));
    end
    total++;
    if (ry_v !== rng(11, 12)) begin
      bad++; $display("FAIL er_ready got=%h want=%h", ry_v, rng(11, 12));
    end
  endtask

  task automatic test_illegal();
    issue(2'b11, 8'h44, 8'h55);
    capture(4);
    total++;
    if (cl_v !== '0 || ck_v !== '0 || oe_v !== '0) begin
      bad++; $display("FAIL il_pins got=%h/%h/%h want=0", cl_v, ck_v, oe_v);
    end
    total++;
    if (rv_v !== rng(1, 1) || er_a[1] !== 1'b1) begin
      bad++; $display("FAIL il_rsp got=%h/%b want=%h/1", rv_v, er_a[1], rng(1, 1));
    end
    total++;
    if (bz_v !== rng(1, 1)) begin
      bad++; $display("FAIL il_busy got=%h want=%h", bz_v, rng(1, 1));
    end
    total++;
    if (ry_v !== rng(2, 4)) begin
      bad++; $display("FAIL il_ready got=%h want=%h", ry_v, rng(2, 4));
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    io_in = 8'h3C;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; req_addr = 8'h22; req_data = 8'h00;
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_ready got=%b want=1", req_ready);
    end
    @(posedge clk);
    #1 req_op = 2'b01; req_addr = 8'h33; req_data = 8'h77;
    clr();
    acc = -1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      sample(k);
      if (acc < 0 && req_ready) acc = k;
      @(posedge clk);
      #1 if (acc == k) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    total++;
    if (acc != 17) begin
      bad++; $display("FAIL b2b_accept got=%0d want=17", acc);
    end
    total++;
    if (cl_v[18:15] !== 4'b1000) begin
      bad++; $display("FAIL b2b_gap got=%b want=1000", cl_v[18:15]);
    end
    total++;
    if (rv_v !== (rng(15, 15) | rng(28, 28))) begin
      bad++;
      $display("FAIL b2b_rsp got=%h want=%h", rv_v, rng(15, 15) | rng(28, 28));
    end
    total++;
    if ({rd_a[15], out_a[18], out_a[22], out_a[24], out_a[26]}
        !== 40'h3C06023377) begin
      bad++;
      $display("FAIL b2b_io got=%h %h %h %h %h want=3c 06 02 33 77",
        rd_a[15], out_a[18], out_a[22], out_a[24], out_a[26]);
    end
  endtask

  task automatic test_reset_mid();
    int nrsp;
    io_in = 8'hC3;
    issue(2'b00, 8'h5A, 8'h00);
    capture(5);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({OSPI_CS, OSPI_CLK, io_oe, busy, rsp_valid} !== 5'b10000) begin
      bad++;
      $display("FAIL rst_mid got=%b want=10000",
        {OSPI_CS, OSPI_CLK, io_oe, busy, rsp_valid});
    end
    reset = 1'b0;
    nrsp = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) nrsp++;
    end
    total++;
    if (nrsp != 0) begin
      bad++; $display("FAIL rst_norsp got=%0d want=0", nrsp);
    end
    io_in = 8'hA6;
    issue(2'b00, 8'h11, 8'h00);
    capture(17);
    total++;
    if (rv_v !== rng(15, 15) || rd_a[15] !== 8'hA6) begin
      bad++;
      $display("FAIL rst_reread got=%h/%h want=%h/a6", rv_v, rd_a[15], rng(15, 15));
    end
    total++;
    if (cl_v !== rng(1, 14) || out_a[3] !== 8'h11) begin
      bad++; $display("FAIL rst_repins got=%h/%h want=%h/11", cl_v, out_a[3], rng(1, 14));
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_program();
    test_erase();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
